// File: rtl/esp_uart_tx_pkg.sv
// Shared types and default parameters for the ESP32 UART transmit path.
package esp_uart_tx_pkg;

  localparam int unsigned ESP_FIFO_AW    = 4;
  localparam int unsigned ESP_ACC_W      = 16;
  localparam int unsigned ESP_BAUD_INC   = 4219;
  localparam int unsigned ESP_BREAK_BITS = 12;
  localparam int unsigned TX_WORD_W      = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } tx_state_e;

  // One queued transmit request: brk set means send a line break instead of data.
  typedef struct packed {
    logic       brk;
    logic [7:0] data;
  } tx_word_t;

endpackage

// File: rtl/esp_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is taken only when a pop frees the slot.
module esp_uart_tx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wrdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rddata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en_c, rd_en_c;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_en_c = rd && !empty;
  assign wr_en_c = wr && (!full || rd_en_c);
  assign rddata  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q + AW'(wr_en_c);
    rptr_d  = rptr_q + AW'(rd_en_c);
    count_d = count_q + (AW+1)'(wr_en_c) - (AW+1)'(rd_en_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wptr_q] <= wrdata;
    end
  end

endmodule

// File: rtl/esp_uart_tx.sv
// ESP32 UART transmitter: buffers 9-bit requests and serialises 8N1 frames or breaks onto uart_txd,
// gated by the ESP's CTS flow control between frames.
module esp_uart_tx
  import esp_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_AW    = ESP_FIFO_AW,
  parameter int unsigned ACC_W      = ESP_ACC_W,
  parameter int unsigned BAUD_INC   = ESP_BAUD_INC,
  parameter int unsigned BREAK_BITS = ESP_BREAK_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [TX_WORD_W-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_fifo_full,
  input  logic                 uart_cts_n,
  output logic                 uart_txd,
  output logic                 tx_busy
);

  localparam int unsigned CNT_W = $clog2((BREAK_BITS > 8) ? BREAK_BITS : 8);

  tx_state_e        state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             txd_q, txd_d;
  logic             cts_meta_q, cts_meta_d;
  logic             cts_s_q, cts_s_d;

  tx_word_t         head;
  logic             fifo_empty, fifo_full;
  logic             pop_c;
  logic [ACC_W:0]   acc_sum_c;
  logic             tick_c;

  esp_uart_tx_fifo #(
    .WIDTH (TX_WORD_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset_n),
    .wr     (tx_wr),
    .wrdata (tx_data),
    .rd     (pop_c),
    .rddata (head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Bit tick is the carry out of the fractional baud accumulator.
  assign acc_sum_c = {1'b0, acc_q} + (ACC_W+1)'(BAUD_INC);
  assign tick_c    = acc_sum_c[ACC_W];

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    txd_d      = txd_q;
    acc_d      = (state_q == ST_IDLE) ? '0 : acc_sum_c[ACC_W-1:0];
    cts_meta_d = uart_cts_n;
    cts_s_d    = cts_meta_q;
    pop_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        // CTS only gates the start of a frame, never one already on the wire.
        if (!fifo_empty && !cts_s_q) begin
          pop_c    = 1'b1;
          shreg_d  = head.data;
          bitcnt_d = '0;
          txd_d    = 1'b0;
          state_d  = head.brk ? ST_BREAK : ST_START;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
          txd_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (bitcnt_q == CNT_W'(7)) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            shreg_d  = {1'b0, shreg_q[7:1]};
            bitcnt_d = bitcnt_q + CNT_W'(1);
            txd_d    = shreg_q[1];
          end
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (tick_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_BREAK: begin
        txd_d = 1'b0;
        if (tick_c) begin
          if (bitcnt_q == CNT_W'(BREAK_BITS - 1)) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      acc_q      <= '0;
      txd_q      <= 1'b1;
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      acc_q      <= acc_d;
      txd_q      <= txd_d;
      cts_meta_q <= cts_meta_d;
      cts_s_q    <= cts_s_d;
    end
  end

  assign uart_txd     = txd_q;
  assign tx_fifo_full = fifo_full;
  assign tx_busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule
